// File: rtl/student_circuit_q1_decoder.sv
// Receive-side decoder for slot-inverted frames: aligns to the SOF strobe,
// tracks the slot phase, re-inverts the tail slots and reports alignment errors.
module student_circuit_q1_decoder #(
    parameter int WIDTH       = 8,
    parameter int FRAME_LEN   = 8,
    parameter int PLAIN_SLOTS = 5,
    parameter int MISS_LIMIT  = 2,
    parameter int ERR_W       = 8
) (
    input  logic                         clk,
    input  logic                         clear_n,
    input  logic                         enc_valid,
    input  logic [WIDTH-1:0]             enc_data,
    input  logic                         enc_sof,
    output logic                         dec_valid,
    output logic [WIDTH-1:0]             dec_data,
    output logic [$clog2(FRAME_LEN)-1:0] dec_slot,
    output logic                         locked,
    output logic                         sof_err,
    output logic [ERR_W-1:0]             err_count
);
    localparam int SLOT_W = $clog2(FRAME_LEN);
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam logic [SLOT_W:0]   PLAIN_CMP = (SLOT_W + 1)'(PLAIN_SLOTS);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic                dec_valid_q, dec_valid_d;
    logic                sof_err_q, sof_err_d;
    logic [WIDTH-1:0]    dec_data_q, dec_data_d;
    logic [SLOT_W-1:0]   dec_slot_q, dec_slot_d;

    logic [SLOT_W-1:0]   cur_slot;
    logic                take_word;
    logic                flag_err;
    logic [MISS_W-1:0]   miss_inc;

    assign miss_inc = miss_q + MISS_W'(1);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            miss_q      <= '0;
            err_q       <= '0;
            dec_valid_q <= 1'b0;
            sof_err_q   <= 1'b0;
            dec_data_q  <= '0;
            dec_slot_q  <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            miss_q      <= miss_d;
            err_q       <= err_d;
            dec_valid_q <= dec_valid_d;
            sof_err_q   <= sof_err_d;
            dec_data_q  <= dec_data_d;
            dec_slot_q  <= dec_slot_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        miss_d      = miss_q;
        err_d       = err_q;
        dec_valid_d = 1'b0;
        sof_err_d   = 1'b0;
        dec_data_d  = dec_data_q;
        dec_slot_d  = dec_slot_q;
        cur_slot    = '0;
        take_word   = 1'b0;
        flag_err    = 1'b0;

        if (enc_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (enc_sof) begin
                        take_word = 1'b1;
                        miss_d    = '0;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    take_word = 1'b1;
                    if (enc_sof) begin
                        // An SOF always realigns; it is only an error off slot 0.
                        if (slot_q != '0) begin
                            flag_err = 1'b1;
                        end else begin
                            miss_d = '0;
                        end
                    end else if (slot_q == '0) begin
                        flag_err = 1'b1;
                        if (miss_inc >= MISS_MAX) begin
                            miss_d  = '0;
                            state_d = HUNT;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        cur_slot = slot_q;
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        if (take_word) begin
            dec_valid_d = 1'b1;
            dec_slot_d  = cur_slot;
            dec_data_d  = ({1'b0, cur_slot} < PLAIN_CMP) ? enc_data : ~enc_data;
            slot_d      = cur_slot + SLOT_W'(1);
        end

        if (flag_err) begin
            sof_err_d = 1'b1;
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    assign dec_valid = dec_valid_q;
    assign dec_data  = dec_data_q;
    assign dec_slot  = dec_slot_q;
    assign locked    = (state_q == LOCKED);
    assign sof_err   = sof_err_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_student_circuit_q1_decoder.sv
// Self-checking bench for the Q1 frame decoder: directed scenarios plus a
// randomized stream compared against a behavioural frame-alignment model.
module tb_student_circuit_q1_decoder;
    localparam int WIDTH       = 8;
    localparam int FRAME_LEN   = 8;
    localparam int PLAIN_SLOTS = 5;
    localparam int MISS_LIMIT  = 2;
    localparam int ERR_W       = 8;
    localparam int ERR_MAX     = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             clear_n;
    logic             enc_valid;
    logic [WIDTH-1:0] enc_data;
    logic             enc_sof;
    logic             dec_valid;
    logic [WIDTH-1:0] dec_data;
    logic [2:0]       dec_slot;
    logic             locked;
    logic             sof_err;
    logic [ERR_W-1:0] err_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit               m_locked;
    int               m_exp;
    int               m_miss;
    int               m_err;
    logic             exp_valid;
    logic             exp_sof_err;
    logic [WIDTH-1:0] exp_data;
    int               exp_slot;

    student_circuit_q1_decoder #(
        .WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN), .PLAIN_SLOTS(PLAIN_SLOTS),
        .MISS_LIMIT(MISS_LIMIT), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .clear_n(clear_n), .enc_valid(enc_valid), .enc_data(enc_data),
        .enc_sof(enc_sof), .dec_valid(dec_valid), .dec_data(dec_data),
        .dec_slot(dec_slot), .locked(locked), .sof_err(sof_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] encode(input int slot, input logic [WIDTH-1:0] w);
        return (slot < PLAIN_SLOTS) ? w : ~w;
    endfunction

    function automatic logic [21:0] dut_vec();
        return {dec_valid, dec_data, dec_slot, locked, sof_err, err_count};
    endfunction

    function automatic logic [21:0] model_vec();
        return {exp_valid, exp_data, 3'(exp_slot), m_locked, exp_sof_err, 8'(m_err)};
    endfunction

    task automatic model_reset();
        m_locked = 1'b0; m_exp = 0; m_miss = 0; m_err = 0;
        exp_valid = 1'b0; exp_sof_err = 1'b0; exp_data = '0; exp_slot = 0;
    endtask

    task automatic model_step(input logic v, input logic [WIDTH-1:0] d, input logic s);
        int  slot;
        bit  emit;
        bit  err;
        slot = 0; emit = 0; err = 0;
        exp_valid = 1'b0; exp_sof_err = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    emit = 1; m_locked = 1; m_miss = 0;
                end
            end else begin
                emit = 1;
                if (s) begin
                    if (m_exp != 0) err = 1;
                    else m_miss = 0;
                end else if (m_exp == 0) begin
                    err = 1;
                    m_miss++;
                    if (m_miss >= MISS_LIMIT) begin
                        m_locked = 0; m_miss = 0;
                    end
                end else begin
                    slot = m_exp;
                end
            end
        end
        if (emit) begin
            exp_valid = 1'b1;
            exp_slot  = slot;
            exp_data  = encode(slot, d);  // inversion is its own inverse
            m_exp     = (slot + 1) % FRAME_LEN;
        end
        if (err) begin
            exp_sof_err = 1'b1;
            m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
        end
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic s);
        clear_n = 1'b1; enc_valid = v; enc_data = d; enc_sof = s;
        model_step(v, d, s);
        @(posedge clk); #1;
    endtask

    task automatic step_reset(input logic v, input logic [WIDTH-1:0] d, input logic s);
        clear_n = 1'b0; enc_valid = v; enc_data = d; enc_sof = s;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step_reset(1'b1, 8'hA5, 1'b1);
        if (dut_vec() !== 22'h0) begin
            errors++; $display("FAIL reset: got %h expected %h", dut_vec(), 22'h0);
        end
        checks++;
    endtask

    task automatic test_hunt_drop();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'($urandom), 1'b0);
            if (dec_valid !== 1'b0 || locked !== 1'b0 || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL hunt_drop %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            checks++;
        end
    endtask

    task automatic test_frame();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < FRAME_LEN; i++) begin
            w = 8'((i + 1) * 17);
            step(1'b1, encode(i, w), i == 0);
            if ({dec_valid, dec_data, dec_slot, locked} !== {1'b1, w, 3'(i), 1'b1}
                || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL frame slot %0d: got %h expected data %h slot %0d locked", i, dut_vec(), w, i);
            end
            checks++;
        end
    endtask

    task automatic test_gaps();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < FRAME_LEN; i++) begin
            w = 8'((i + 1) * 17);
            step(1'b1, encode(i, w), i == 0);
            if (dec_valid !== 1'b1 || dec_data !== w || dec_slot !== 3'(i)) begin
                errors++; $display("FAIL gaps word %0d: got %h expected data %h slot %0d", i, dut_vec(), w, i);
            end
            checks++;
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 8'($urandom), 1'($urandom));
                if (dec_valid !== 1'b0 || dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL gaps idle %0d.%0d: got %h expected %h", i, g, dut_vec(), model_vec());
                end
                checks++;
            end
        end
    endtask

    task automatic test_early_sof();
        for (int i = 0; i < 3; i++) step(1'b1, encode(i, 8'($urandom)), i == 0);
        step(1'b1, 8'h5C, 1'b1);
        if ({sof_err, err_count, dec_valid, dec_slot, dec_data} !== {1'b1, 8'd1, 1'b1, 3'd0, 8'h5C}) begin
            errors++; $display("FAIL early_sof: got %h expected err 1 slot 0 data 5c", dut_vec());
        end
        checks++;
        for (int i = 1; i < FRAME_LEN; i++) begin
            step(1'b1, encode(i, 8'($urandom)), 1'b0);
            if (dec_slot !== 3'(i) || sof_err !== 1'b0 || dut_vec() !== model_vec()) begin
                errors++; $display("FAIL early_sof follow %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            checks++;
        end
    endtask

    task automatic test_missing_sof();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                step(1'b1, encode(i, 8'($urandom)), 1'b0);
                if (f == 1 && i > 0) begin
                    if (dec_valid !== 1'b0 || locked !== 1'b0) begin
                        errors++; $display("FAIL missing_sof drop %0d: got %h expected no output", i, dut_vec());
                    end
                    checks++;
                end else if (i == 0) begin
                    if ({sof_err, dec_valid, dec_slot, locked, err_count} !== {1'b1, 1'b1, 3'd0, 1'(f == 0), 8'(2 + f)}) begin
                        errors++; $display("FAIL missing_sof frame %0d: got %h expected locked=%0d err=%0d", f, dut_vec(), f == 0, 2 + f);
                    end
                    checks++;
                end
                if (dut_vec() !== model_vec()) begin
                    errors++; $display("FAIL missing_sof model %0d.%0d: got %h expected %h", f, i, dut_vec(), model_vec());
                end
                checks++;
            end
        end
    endtask

    task automatic test_saturation_and_clear();
        step(1'b1, 8'($urandom), 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'($urandom), 1'b1);
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL saturate %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            checks++;
        end
        if (err_count !== 8'hFF) begin
            errors++; $display("FAIL saturate final: got %0d expected 255", err_count);
        end
        checks++;
        step(1'b1, encode(1, 8'($urandom)), 1'b0);
        step(1'b1, encode(2, 8'($urandom)), 1'b0);
        step_reset(1'b1, 8'($urandom), 1'b1);
        if (dut_vec() !== 22'h0) begin
            errors++; $display("FAIL clear_midframe: got %h expected %h", dut_vec(), 22'h0);
        end
        checks++;
        step(1'b1, 8'($urandom), 1'b0);
        if (dec_valid !== 1'b0 || locked !== 1'b0) begin
            errors++; $display("FAIL clear_then_hunt: got %h expected no output", dut_vec());
        end
        checks++;
    endtask

    task automatic test_random();
        logic v, s;
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 9) < 7);
            if (!m_locked) s = ($urandom_range(0, 3) == 0);
            else if (m_exp == 0) s = ($urandom_range(0, 9) < 8);
            else s = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) step_reset(v, 8'($urandom), s);
            else step(v, 8'($urandom), s);
            if (dut_vec() !== model_vec()) begin
                errors++; $display("FAIL random %0d: got %h expected %h", i, dut_vec(), model_vec());
            end
            checks++;
        end
    endtask

    initial begin
        clear_n = 1'b0; enc_valid = 1'b0; enc_data = '0; enc_sof = 1'b0;
        model_reset();
        test_reset();
        test_hunt_drop();
        test_frame();
        test_gaps();
        test_early_sof();
        test_missing_sof();
        test_saturation_and_clear();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
